// File: rtl/key_pkg.sv
// Shared constants for the song-player button front-end: key encodings,
// debounce default and the channel index of the stop button.
package key_pkg;

    localparam logic [3:0] KEY_IDLE  = 4'b0000;
    localparam logic [3:0] KEY_SONG1 = 4'b0001;
    localparam logic [3:0] KEY_SONG2 = 4'b0010;
    localparam logic [3:0] KEY_SONG3 = 4'b0100;

    // 20 ms of stable samples at 5 MHz
    localparam int DB_CYCLES_DEFAULT = 100000;

    // btn_raw bit that acts as stop
    localparam int STOP_BIT = 3;

    // four song/stop buttons plus the tempo button
    localparam int NUM_BTN = 4;
    localparam int NUM_CH  = 5;
    localparam int SEL_CH  = 4;

endpackage

// File: rtl/debounce_cell.sv
// One button channel: 2-flop synchronizer followed by a counter that only
// accepts a new level after DB_CYCLES consecutive differing samples.
// Emits one-cycle rise/fall strobes aligned with the stable-level change.
module debounce_cell
    import key_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    // last count value before a differing level is accepted
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // two-flop synchronizer, nothing between the flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // stability counter; any agreeing sample restarts it, so glitches never land
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_p1;
                cnt    <= '0;
                rise   <= sync_p1;
                fall   <= ~sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_input_ctrl.sv
// Button front-end for the song player: debounces the four song/stop buttons
// and the tempo button, latches the one-hot song key and exposes the clean
// tempo level whose falling edges the tempo logic counts.
module key_input_ctrl
    import key_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 17
) (
    input  logic       clk_5MHz,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       sel_raw,
    output logic [3:0] key,
    output logic       select,
    output logic       key_changed
);

    logic [NUM_CH-1:0] raw_all;
    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [3:0]        key_next;

    // Only rise strobes drive the key latch and only the tempo level drives
    // select; the remaining debouncer outputs are deliberately left unused.
    logic unused_edges;
    assign unused_edges = ^{stable[NUM_BTN-1:0], fall};

    assign raw_all = {sel_raw, btn_raw};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_db
        debounce_cell #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk    (clk_5MHz),
            .rst    (rst),
            .raw    (raw_all[g]),
            .stable (stable[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

    // key latch: stop wins, then lowest song button; pressing the playing song toggles it off
    always_comb begin
        key_next = key;
        if (rise[STOP_BIT]) begin
            key_next = KEY_IDLE;
        end else if (rise[0]) begin
            key_next = (key == KEY_SONG1) ? KEY_IDLE : KEY_SONG1;
        end else if (rise[1]) begin
            key_next = (key == KEY_SONG2) ? KEY_IDLE : KEY_SONG2;
        end else if (rise[2]) begin
            key_next = (key == KEY_SONG3) ? KEY_IDLE : KEY_SONG3;
        end
    end

    // registered outputs: key, its change strobe, and the debounced tempo level
    always_ff @(posedge clk_5MHz or posedge rst) begin
        if (rst) begin
            key         <= KEY_IDLE;
            key_changed <= 1'b0;
            select      <= 1'b0;
        end else begin
            key         <= key_next;
            key_changed <= (key_next != key);
            select      <= stable[SEL_CH];
        end
    end

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl with a short debounce window (8 cycles).
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_key_input_ctrl;

    localparam int DB = 8;

    logic       clk_5MHz = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] btn_raw  = 4'b0000;
    logic       sel_raw  = 1'b0;
    logic [3:0] key;
    logic       select;
    logic       key_changed;

    int errors = 0;
    int checks = 0;
    int kc_cnt = 0;

    key_input_ctrl #(
        .DB_CYCLES (DB),
        .CNT_W     (4)
    ) dut (
        .clk_5MHz    (clk_5MHz),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .sel_raw     (sel_raw),
        .key         (key),
        .select      (select),
        .key_changed (key_changed)
    );

    always #5 clk_5MHz = ~clk_5MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance n falling edges, counting key_changed pulses seen
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_5MHz);
            if (key_changed === 1'b1) kc_cnt++;
        end
    endtask

    // clean press then clean release, each long enough to be accepted
    task automatic press(input logic [3:0] bits);
        kc_cnt  = 0;
        btn_raw = bits;
        step(12);
        btn_raw = 4'b0000;
        step(12);
    endtask

    initial begin
        int rises;
        int falls;
        int width;
        int minw;
        logic prev;

        // reset state
        rst = 1'b1;
        step(3);
        chk("rst_key", 32'(key), 32'h0);
        chk("rst_select", 32'(select), 32'h0);
        chk("rst_kc", 32'(key_changed), 32'h0);
        rst = 1'b0;
        step(2);

        // 1: hold song1; key appears exactly 11 cycles after the raw edge
        btn_raw = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            chk($sformatf("t1_key_c%0d", i), 32'(key), (i >= 11) ? 32'h1 : 32'h0);
            chk($sformatf("t1_kc_c%0d", i), 32'(key_changed), (i == 11) ? 32'h1 : 32'h0);
            chk($sformatf("t1_sel_c%0d", i), 32'(select), 32'h0);
        end
        btn_raw = 4'b0000;
        step(12);
        chk("t1_release_hold", 32'(key), 32'h1);

        // 2: glitchy presses on btn1 are rejected, then a clean hold is accepted
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        kc_cnt  = 0;
        btn_raw = 4'b0010; step(5);
        btn_raw = 4'b0000; step(3);
        btn_raw = 4'b0010; step(5);
        btn_raw = 4'b0000; step(15);
        chk("t2_glitch_key", 32'(key), 32'h0);
        chk("t2_glitch_kc", 32'(kc_cnt), 32'h0);
        btn_raw = 4'b0010;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            chk($sformatf("t2_key_c%0d", i), 32'(key), (i >= 11) ? 32'h2 : 32'h0);
            chk($sformatf("t2_kc_c%0d", i), 32'(key_changed), (i == 11) ? 32'h1 : 32'h0);
        end
        btn_raw = 4'b0000;
        step(12);
        chk("t2_after_release", 32'(key), 32'h2);

        // 3: toggle off, select song3, stop
        press(4'b0010);
        chk("t3_toggle_key", 32'(key), 32'h0);
        chk("t3_toggle_kc", 32'(kc_cnt), 32'h1);
        press(4'b0100);
        chk("t3_song3_key", 32'(key), 32'h4);
        chk("t3_song3_kc", 32'(kc_cnt), 32'h1);
        press(4'b1000);
        chk("t3_stop_key", 32'(key), 32'h0);
        chk("t3_stop_kc", 32'(kc_cnt), 32'h1);

        // 4: simultaneous rises: lowest song wins, stop beats everything
        press(4'b0111);
        chk("t4_multi_key", 32'(key), 32'h1);
        chk("t4_multi_kc", 32'(kc_cnt), 32'h1);
        press(4'b1111);
        chk("t4_all_key", 32'(key), 32'h0);
        chk("t4_all_kc", 32'(kc_cnt), 32'h1);
        press(4'b1111);
        chk("t4_all_idle_key", 32'(key), 32'h0);
        chk("t4_all_idle_kc", 32'(kc_cnt), 32'h0);

        // 5: three tempo presses give three 12-cycle select pulses
        rises  = 0;
        falls  = 0;
        width  = 0;
        minw   = 1000;
        prev   = select;
        kc_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            for (int h = 0; h < 2; h++) begin
                sel_raw = (h == 0);
                for (int c = 0; c < 12; c++) begin
                    step(1);
                    if (select && !prev) begin
                        rises++;
                        width = 0;
                    end
                    if (select) width++;
                    if (!select && prev) begin
                        falls++;
                        if (width < minw) minw = width;
                    end
                    prev = select;
                end
            end
        end
        chk("t5_rises", 32'(rises), 32'd3);
        chk("t5_falls", 32'(falls), 32'd3);
        chk("t5_min_width", 32'(minw), 32'd12);
        chk("t5_key", 32'(key), 32'h0);
        chk("t5_kc", 32'(kc_cnt), 32'h0);

        // 6: reset mid-debounce with btn0 held; accepted again after release
        press(4'b0010);
        chk("t6_pre_key", 32'(key), 32'h2);
        btn_raw = 4'b0001;
        step(7);
        rst = 1'b1;
        #1;
        chk("t6_async_key", 32'(key), 32'h0);
        chk("t6_async_kc", 32'(key_changed), 32'h0);
        chk("t6_async_sel", 32'(select), 32'h0);
        step(2);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            chk($sformatf("t6_key_c%0d", i), 32'(key), (i >= 11) ? 32'h1 : 32'h0);
        end
        btn_raw = 4'b0000;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
